// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for multicycle_control_unit.
// The master side is the control unit. It receives the fetched instruction word,
// the memory ready flag and the ALU zero flag. It drives the datapath select lines,
// the datapath strobes and the status outputs. The slave side is the datapath or
// the memory model, with the directions mirrored.
interface multicycle_control_unit_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 16
);
  // datapath -> control
  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic               zero;

  // control -> datapath: select lines
  logic               immgenop;
  logic [1:0]         aluop;
  logic               aluin1;
  logic               aluin2;
  logic [1:0]         alusrc;

  // control -> datapath: strobes
  logic               memread;
  logic               memwrite;
  logic               pcwrite;
  logic               irwrite;
  logic               regwrite;

  // status
  logic [2:0]         state;
  logic               halted;
  logic               trap;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  instr, mem_ready, zero,
    output immgenop, aluop, aluin1, aluin2, alusrc,
    output memread, memwrite, pcwrite, irwrite, regwrite,
    output state, halted, trap, retired
  );

  modport slave (
    output instr, mem_ready, zero,
    input  immgenop, aluop, aluin1, aluin2, alusrc,
    input  memread, memwrite, pcwrite, irwrite, regwrite,
    input  state, halted, trap, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the 16-bit processor.
// Each instruction passes through FETCH, DECODE and EXEC. Some instructions also pass
// through MEM and WB. Memory accesses in FETCH and MEM wait for mem_ready. A bounded
// wait counter limits that wait. An illegal opcode, a memory timeout or a HALT parks
// the unit in a sticky state until the next reset.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; every output reads 0 while it is low
//   bus    multicycle_control_unit_if.master:
//            in : instr, mem_ready, zero
//            out: immgenop, aluop, aluin1, aluin2, alusrc,
//                 memread, memwrite, pcwrite, irwrite, regwrite,
//                 state, halted, trap, retired
module multicycle_control_unit #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned MEM_TIMEOUT = 15,  // 1..255
  parameter int unsigned CNT_W       = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  multicycle_control_unit_if.master    bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [3:0] OpR    = 4'h0;
  localparam logic [3:0] OpI    = 4'h1;
  localparam logic [3:0] OpLw   = 4'h2;
  localparam logic [3:0] OpSw   = 4'h3;
  localparam logic [3:0] OpBeq  = 4'h4;
  localparam logic [3:0] OpJmp  = 4'h5;
  localparam logic [3:0] OpHalt = 4'hF;

  // The wait that would bring the count to MEM_TIMEOUT traps instead of counting.
  localparam logic [7:0]       WaitLast = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;  // opcode field of IR: the only IR bits that steer control
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             trap_q, trap_d;

  logic       immgenop, aluin1, aluin2;
  logic [1:0] aluop, alusrc;
  logic       memread, memwrite, pcwrite, irwrite, regwrite;

  logic [3:0] fetch_op;
  logic       op_legal;
  logic       mem_timeout;
  logic       unused_instr;

  assign fetch_op     = bus.instr[INSTR_W-1 -: 4];
  assign unused_instr = ^bus.instr[INSTR_W-5:0];
  assign op_legal     = op_q inside {OpR, OpI, OpLw, OpSw, OpBeq, OpJmp};
  assign mem_timeout  = !bus.mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    immgenop  = 1'b0;
    aluop     = 2'b00;
    aluin1    = 1'b0;
    aluin2    = 1'b0;
    alusrc    = 2'b00;
    memread   = 1'b0;
    memwrite  = 1'b0;
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;

    unique case (state_q)
      StFetch: begin
        // ALU computes PC+1 while the instruction word is read.
        memread = 1'b1;
        if (bus.mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          op_d    = fetch_op;
          state_d = StDecode;
        end else if (mem_timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      StDecode: begin
        if (op_q == OpHalt) begin
          state_d = StHalt;
        end else if (op_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end

      StExec: begin
        case (op_q)
          OpR: begin
            aluin1  = 1'b1;
            aluop   = 2'b10;
            state_d = StWb;
          end
          OpI: begin
            aluin1  = 1'b1;
            aluin2  = 1'b1;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            // Effective address = rA + I-format immediate.
            aluin1  = 1'b1;
            aluin2  = 1'b1;
            state_d = StMem;
          end
          OpBeq: begin
            aluin1  = 1'b1;
            aluop   = 2'b01;
            alusrc  = 2'b01;
            pcwrite = bus.zero;
            state_d = StFetch;
          end
          OpJmp: begin
            immgenop = 1'b1;
            alusrc   = 2'b10;
            pcwrite  = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StTrap;  // DECODE filters these; kept as a safe exit
        endcase
      end

      StMem: begin
        memread  = (op_q == OpLw);
        memwrite = (op_q == OpSw);
        if (bus.mem_ready) begin
          state_d = (op_q == OpLw) ? StWb : StFetch;
        end else if (mem_timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      StWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end

      StHalt, StTrap: ;

      default: state_d = StTrap;
    endcase

    // Each new FETCH or MEM visit gets a fresh wait budget.
    if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
      wait_d = 8'd0;
    end
    // An instruction retires on its way back to FETCH.
    if ((state_d == StFetch) && (state_q inside {StExec, StMem, StWb})) begin
      retired_d = retired_q + CntOne;
    end
    if (state_d == StHalt) halted_d = 1'b1;
    if (state_d == StTrap) trap_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= 4'h0;
      wait_q    <= 8'd0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
    end
  end

  // The controls decode from the FETCH reset state. They are masked so that the
  // datapath sees no strobe while reset is held.
  assign bus.immgenop = rst_n & immgenop;
  assign bus.aluop    = rst_n ? aluop : 2'b00;
  assign bus.aluin1   = rst_n & aluin1;
  assign bus.aluin2   = rst_n & aluin2;
  assign bus.alusrc   = rst_n ? alusrc : 2'b00;
  assign bus.memread  = rst_n & memread;
  assign bus.memwrite = rst_n & memwrite;
  assign bus.pcwrite  = rst_n & pcwrite;
  assign bus.irwrite  = rst_n & irwrite;
  assign bus.regwrite = rst_n & regwrite;
  assign bus.state    = state_q;
  assign bus.halted   = halted_q;
  assign bus.trap     = trap_q;
  assign bus.retired  = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle control unit for the 16-bit processor, successor to the single-step control/memory pairing. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Memory accesses use a ready handshake with a configurable wait-state timeout, and illegal opcodes, timeouts and HALT are trapped. It drives the datapath select lines (IMMGENOP, ALUOP, ALUIN1, ALUIN2, ALUSRC, MemRead, MemWrite, PCWrite) plus IRWrite/RegWrite, and counts retired instructions.

## Interface
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4]
- MEM_TIMEOUT, 15, maximum wait cycles per memory access before trap (1..255)
- CNT_W, 16, retired-instruction counter width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- instr  in  INSTR_W  memory read data; IR captured from it on IRWrite
- mem_ready  in  1  memory completes current access this cycle
- zero  in  1  ALU zero flag, sampled in EXEC
- IMMGENOP  out  1  0 = I-format immediate, 1 = jump immediate
- ALUOP  out  2  00 add, 01 sub, 10 funct-decoded
- ALUIN1  out  1  1 = register A, 0 = PC
- ALUIN2  out  1  1 = immediate, 0 = register B
- ALUSRC  out  2  PC source: 00 PC+1, 01 branch target, 10 jump target
- MemRead, MemWrite, PCWrite, IRWrite, RegWrite  out  1 each  datapath strobes
- state  out  3  current state encoding
- halted, trap  out  1 each  sticky status
- retired  out  CNT_W  completed-instruction count

## Operation
- Opcodes: 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 JMP, F HALT. All others are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- FETCH: MemRead=1, ALUIN1=0, ALUSRC=00. When mem_ready=1, IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
- DECODE: no strobes. HALT goes to HALT, illegal goes to TRAP, all others go to EXEC.
- EXEC, by opcode:
  - R: ALUIN1=1, ALUIN2=0, ALUOP=10, then WB.
  - I: ALUIN1=1, ALUIN2=1, IMMGENOP=0, ALUOP=00, then WB.
  - LW/SW: same controls as I, then MEM.
  - BEQ: ALUIN1=1, ALUIN2=0, ALUOP=01. PCWrite=zero, ALUSRC=01, then FETCH.
  - JMP: IMMGENOP=1, PCWrite=1, ALUSRC=10, then FETCH.
- MEM: LW asserts MemRead and SW asserts MemWrite, both held until mem_ready. On mem_ready, LW goes to WB and SW goes to FETCH.
- WB: RegWrite=1, then FETCH.
- retired increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- HALT: halted=1, all strobes 0. Held until reset.
- TRAP: trap=1, all strobes 0. Held until reset.
- Wait counter: cleared on entry to FETCH or MEM, and increments each cycle mem_ready=0 in that state. If it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP.

## Timing
- Control outputs are combinational from state, opcode, mem_ready and zero. state, IR, retired, halted, trap and the wait counter are registered.
- Reset (RST_N=0): state=FETCH, IR=0, retired=0, halted=0, trap=0, wait counter=0. All outputs are forced to 0 while RST_N is low, including MemRead. Asserting reset mid-instruction aborts it with no partial count.
- Zero-wait cycle counts: R/I/SW = 4, LW = 5, BEQ/JMP = 3. Each wait state adds 1.
- mem_ready is ignored outside FETCH and MEM.
- mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: the access completes and no trap occurs.
- Counter wrap and instruction completion in the same cycle: retired goes 2^CNT_W-1 → 0. No other effect.
- zero is sampled only in EXEC of BEQ. PCWrite is low in that cycle if zero=0.

## Test plan
- Reset, then ADD 0x0123 with mem_ready tied 1 → states 0,1,2,4,0. RegWrite high one cycle in WB, retired=1 after 4 cycles.
- LW 0x2xxx with 2 wait states in MEM → MemRead high 3 cycles in MEM, RegWrite in WB, 7 cycles total, retired=1.
- BEQ 0x4005: zero=1 → PCWrite=1, ALUSRC=01 in EXEC. zero=0 → PCWrite=0. Both take 3 cycles.
- Opcode 0x7 → TRAP after DECODE, trap=1, all strobes 0 for 20 cycles. RST_N low → trap=0, state=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → TRAP after 15 wait cycles. Repeat with mem_ready=1 on cycle 15 → no trap.
- JMP then HALT (0xF000) → halted=1, retired=1. Pull RST_N low mid-EXEC → all outputs 0 immediately.
